// File: rtl/cam_i2c_target.sv
// I2C target exposing a 16-bit auto-incrementing register pointer and a byte-wide
// register port; SCL/SDA are oversampled by clk and all bus edges come from synchronised samples.
module cam_i2c_target #(
   parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   input  logic [7:0]  reg_rdata,
   output logic        busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      ACK_DEV,
      REG_HI,
      ACK_HI,
      REG_LO,
      ACK_LO,
      WR_DATA,
      ACK_WR,
      RD_DATA,
      RD_ACK,
      IGNORE
   } state_t;

   // two-flop synchronisers plus one delayed copy for edge detection
   logic scl_s1, scl_s2, scl_d;
   logic sda_s1, sda_s2, sda_d;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [DATA_W-1:0]   addr_hi_q, addr_hi_d;
   logic                rnw_q, rnw_d;
   logic                sda_oe_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic                we_d;
   logic                busy_d;

   logic scl_rise, scl_fall, start_det, stop_det, byte_done;

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
   assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
   assign byte_done = (bit_cnt_q == BYTE_BITS);

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         scl_s1    <= 1'b1;
         scl_s2    <= 1'b1;
         scl_d     <= 1'b1;
         sda_s1    <= 1'b1;
         sda_s2    <= 1'b1;
         sda_d     <= 1'b1;
         state_q   <= IDLE;
         bit_cnt_q <= CNT_W'(1);
         shreg_q   <= '0;
         addr_hi_q <= '0;
         rnw_q     <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         scl_s1    <= scl_in;
         scl_s2    <= scl_s1;
         scl_d     <= scl_s2;
         sda_s1    <= sda_in;
         sda_s2    <= sda_s1;
         sda_d     <= sda_s2;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         addr_hi_q <= addr_hi_d;
         rnw_q     <= rnw_d;
         sda_oe    <= sda_oe_d;
         reg_addr  <= addr_d;
         reg_wdata <= wdata_d;
         reg_we    <= we_d;
         busy      <= busy_d;
      end
   end

   // next-state and output logic; bus conditions override bit handling
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      addr_hi_d = addr_hi_q;
      rnw_d     = rnw_q;
      sda_oe_d  = sda_oe;
      addr_d    = reg_addr;
      wdata_d   = reg_wdata;
      we_d      = 1'b0;
      busy_d    = busy;

      // pointer advances the cycle after each write strobe
      if (reg_we) addr_d = reg_addr + ADDR_W'(1);

      if (stop_det) begin
         state_d   = IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_det) begin
         state_d   = DEV_ADDR;
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            DEV_ADDR, REG_HI, REG_LO, WR_DATA: begin
               if (scl_rise && !byte_done) begin
                  shreg_d   = {shreg_q[DATA_W-2:0], sda_s2};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end else if (scl_fall && byte_done) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b1;
                  if (state_q == DEV_ADDR) begin
                     if (shreg_q[7:1] == SLAVE_ADDR) begin
                        state_d = ACK_DEV;
                        rnw_d   = shreg_q[0];
                        busy_d  = 1'b1;
                     end else begin
                        state_d  = IGNORE;
                        sda_oe_d = 1'b0;
                     end
                  end else if (state_q == REG_HI) begin
                     addr_hi_d = shreg_q;
                     state_d   = ACK_HI;
                  end else if (state_q == REG_LO) begin
                     addr_d  = {addr_hi_q, shreg_q};
                     state_d = ACK_LO;
                  end else begin
                     wdata_d = shreg_q;
                     we_d    = 1'b1;
                     state_d = ACK_WR;
                  end
               end
            end

            ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  if (state_q == ACK_DEV && rnw_q) begin
                     state_d  = RD_DATA;
                     shreg_d  = reg_rdata;
                     sda_oe_d = ~reg_rdata[DATA_W-1];
                  end else if (state_q == ACK_DEV) begin
                     state_d = REG_HI;
                  end else if (state_q == ACK_HI) begin
                     state_d = REG_LO;
                  end else begin
                     state_d = WR_DATA;
                  end
               end
            end

            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end else if (scl_fall) begin
                  if (byte_done) begin
                     state_d   = RD_ACK;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                  end else begin
                     shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
                     sda_oe_d = ~shreg_q[DATA_W-2];
                  end
               end
            end

            // master ACK keeps the burst going, NACK parks us until the next bus condition
            RD_ACK: begin
               sda_oe_d = 1'b0;
               if (scl_rise) begin
                  if (sda_s2) state_d = IGNORE;
                  else        addr_d  = reg_addr + ADDR_W'(1);
               end else if (scl_fall) begin
                  state_d   = RD_DATA;
                  shreg_d   = reg_rdata;
                  sda_oe_d  = ~reg_rdata[DATA_W-1];
                  bit_cnt_d = '0;
               end
            end

            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_i2c_target.sv
// Bench for cam_i2c_target: bit-level I2C master, pointer/memory reference model,
// and scoreboards for per-slot SDA drive and register write strobes.
module tb_cam_i2c_target;

   localparam logic [6:0] SLAVE = 7'h10;
   localparam int Q = 6;

   logic        clk;
   logic        reset_n;
   logic        scl_m;
   logic        sda_m;
   logic        sda_oe;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        reg_we;
   logic [7:0]  reg_rdata;
   logic        busy;
   logic        sda_line;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   bit          exp_slot[$];
   logic [23:0] exp_we[$];
   logic [7:0]  wbuf[$];
   logic [15:0] ptr_m;

   assign sda_line = sda_m & ~sda_oe;

   cam_i2c_target #(.SLAVE_ADDR(SLAVE)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // register file behind the port: data valid one clock after the address
   always @(posedge clk) reg_rdata <= mem_val(reg_addr);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_cond();
      sda_m = 1'b1;
      tick(Q);
      if (!scl_m) begin
         exp_slot.push_back(1'b0);
         scl_m = 1'b1;
         tick(Q);
      end
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic stop_cond();
      sda_m = 1'b0;
      tick(Q);
      exp_slot.push_back(1'b0);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b1;
      tick(Q);
   endtask

   task automatic bit_slot(input bit b, input bit exp_oe);
      sda_m = b;
      tick(Q);
      exp_slot.push_back(exp_oe);
      scl_m = 1'b1;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, input bit exp_ack);
      for (int i = 7; i >= 0; i--) bit_slot(d[i], 1'b0);
      bit_slot(1'b1, exp_ack);
   endtask

   task automatic read_byte(input logic [7:0] exp_d, input bit m_ack);
      for (int i = 7; i >= 0; i--) bit_slot(1'b1, ~exp_d[i]);
      bit_slot(~m_ack, 1'b0);
   endtask

   task automatic wr_txn(input logic [15:0] a, input bit do_stop);
      start_cond();
      write_byte({SLAVE, 1'b0}, 1'b1);
      write_byte(a[15:8], 1'b1);
      write_byte(a[7:0], 1'b1);
      ptr_m = a;
      foreach (wbuf[i]) begin
         exp_we.push_back({ptr_m, wbuf[i]});
         write_byte(wbuf[i], 1'b1);
         ptr_m = ptr_m + 16'd1;
      end
      if (do_stop) stop_cond();
   endtask

   task automatic rd_txn(input int n, input bit extra);
      start_cond();
      write_byte({SLAVE, 1'b1}, 1'b1);
      for (int i = 0; i < n; i++) begin
         bit ack;
         ack = (i != n - 1);
         read_byte(mem_val(ptr_m), ack);
         if (ack) ptr_m = ptr_m + 16'd1;
      end
      if (extra) write_byte(8'h5C, 1'b0);
      stop_cond();
   endtask

   // SDA drive scoreboard: one expectation per SCL high phase
   initial begin
      wait (mon_en);
      forever begin
         @(posedge scl_m);
         #1;
         n_tests++;
         if (exp_slot.size() == 0) begin
            n_fail++;
            $display("FAIL slot_unexpected sda_oe=%0b", sda_oe);
         end else begin
            bit e;
            e = exp_slot.pop_front();
            if (sda_oe !== e) begin
               n_fail++;
               $display("FAIL slot_drive got sda_oe=%0b want %0b at t=%0t", sda_oe, e, $time);
            end
         end
      end
   end

   // write strobe scoreboard
   initial begin
      wait (mon_en);
      forever begin
         @(posedge clk);
         #1;
         if (reg_we === 1'b1) begin
            n_tests++;
            if (exp_we.size() == 0) begin
               n_fail++;
               $display("FAIL reg_we_unexpected addr=0x%04h data=0x%02h", reg_addr, reg_wdata);
            end else begin
               logic [23:0] e;
               e = exp_we.pop_front();
               if ({reg_addr, reg_wdata} !== e) begin
                  n_fail++;
                  $display("FAIL reg_we addr/data got 0x%06h want 0x%06h", {reg_addr, reg_wdata}, e);
               end
            end
         end
      end
   end

   initial begin
      scl_m   = 1'b1;
      sda_m   = 1'b1;
      reset_n = 1'b0;
      ptr_m   = 16'h0000;
      tick(4);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_reg_we", 32'(reg_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_reg_addr", 32'(reg_addr), 32'h0);
      check("rst_reg_wdata", 32'(reg_wdata), 32'h0);
      reset_n = 1'b1;
      tick(4);
      mon_en = 1'b1;

      // single byte write to 0x0100
      wbuf.delete();
      wbuf.push_back(8'h01);
      wr_txn(16'h0100, 1'b0);
      check("wr_busy_mid", 32'(busy), 32'd1);
      check("wr_ptr_after", 32'(reg_addr), 32'(ptr_m));
      stop_cond();
      check("wr_busy_after_stop", 32'(busy), 32'd0);

      // foreign address: no ACK, never busy
      start_cond();
      write_byte(8'h22, 1'b0);
      check("nomatch_busy", 32'(busy), 32'd0);
      check("nomatch_sda_oe", 32'(sda_oe), 32'd0);
      stop_cond();

      // burst across the pointer wrap
      wbuf.delete();
      wbuf.push_back(8'hAA);
      wbuf.push_back(8'hBB);
      wr_txn(16'hFFFF, 1'b1);
      check("wrap_ptr", 32'(reg_addr), 32'(ptr_m));

      // pointer set, repeated START, read ACK then NACK, ignored byte, STOP
      wbuf.delete();
      wr_txn(16'h3000, 1'b0);
      rd_txn(2, 1'b1);
      check("rd_ptr_after_nack", 32'(reg_addr), 32'(ptr_m));
      check("rd_busy_after_stop", 32'(busy), 32'd0);

      // read from the current pointer without setting it
      rd_txn(1, 1'b0);

      // STOP after four data bits discards the byte
      wbuf.delete();
      wr_txn(16'h1234, 1'b0);
      for (int i = 0; i < 4; i++) bit_slot(i[0], 1'b0);
      stop_cond();
      tick(20);
      check("partial_busy", 32'(busy), 32'd0);
      check("partial_sda_oe", 32'(sda_oe), 32'd0);
      check("partial_ptr", 32'(reg_addr), 32'h1234);

      // randomized write bursts and reads
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            logic [15:0] a;
            int n;
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'hFFFE;
            n = $urandom_range(1, 3);
            wbuf.delete();
            for (int j = 0; j < n; j++) wbuf.push_back(8'($urandom));
            wr_txn(a, 1'b1);
         end else begin
            rd_txn($urandom_range(1, 3), 1'b0);
         end
         check("rand_ptr", 32'(reg_addr), 32'(ptr_m));
      end

      // reset during the device-address ACK slot
      start_cond();
      for (int i = 7; i >= 0; i--) bit_slot(i == 5, 1'b0);
      sda_m = 1'b1;
      tick(Q);
      check("pre_rst_ack", 32'(sda_oe), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
      check("mid_rst_reg_addr", 32'(reg_addr), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      tick(3);
      reset_n = 1'b1;
      ptr_m = 16'h0000;
      tick(2);
      exp_slot.push_back(1'b0);
      scl_m = 1'b1;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
      write_byte({SLAVE, 1'b0}, 1'b0);
      write_byte(8'h00, 1'b0);
      stop_cond();
      check("post_rst_ptr", 32'(reg_addr), 32'(ptr_m));
      check("post_rst_busy", 32'(busy), 32'd0);

      tick(10);
      check("slot_queue_empty", 32'(exp_slot.size()), 32'd0);
      check("we_queue_empty", 32'(exp_we.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
